// File: rtl/row_bias.sv
// row_bias: per-row random digit-order source built by an LFSR-driven Fisher-Yates shuffle.
// Define ROW_BIAS_PROTOCOL_CHECK_EN to enable the sticky lookup-protocol error flag.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module row_bias #(
  parameter int LEN   = `GRID_LEN,
  parameter int SEEDW = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [SEEDW-1:0] seed,
  output logic             ready,
  input  logic [LEN-1:0]   biasidx,
  output logic [LEN-1:0]   valtotry,
  output logic             err
);

  localparam int IDXW = $clog2(LEN);
  localparam logic [SEEDW-1:0] LFSR_DEFAULT = SEEDW'(16'hACE1);

  typedef enum logic [1:0] {S_INIT, S_SHUFFLE, S_READY} state_t;

  function automatic logic [SEEDW-1:0] lfsr_step(input logic [SEEDW-1:0] cur);
    lfsr_step = (cur >> 1) ^ (cur[0] ? SEEDW'(16'hB400) : '0);
  endfunction

  state_t            state_q, state_d;
  logic [SEEDW-1:0]  lfsr_q, lfsr_d;
  logic [IDXW-1:0]   i_q, i_d;
  logic [LEN-1:0]    perm_q [LEN];
  logic [LEN-1:0]    perm_d [LEN];
  logic [LEN-1:0]    valtotry_q, valtotry_d;
  logic [IDXW-1:0]   j;
  logic              accept;
  logic [LEN-1:0]    perm_i, perm_j, lookup;

  // Candidate slot comes from the pre-advance LFSR value; out-of-range draws are rejected.
  always_comb begin
    j      = lfsr_q[IDXW-1:0];
    accept = (j <= i_q);
    perm_i = '0;
    perm_j = '0;
    for (int k = 0; k < LEN; k++) begin
      if (IDXW'(k) == i_q) perm_i = perm_q[k];
      if (IDXW'(k) == j)   perm_j = perm_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    i_d     = i_q;
    for (int k = 0; k < LEN; k++) perm_d[k] = perm_q[k];

    if (start) begin
      state_d = S_INIT;
    end else begin
      case (state_q)
        S_INIT: begin
          for (int k = 0; k < LEN; k++) perm_d[k] = LEN'(1) << k;
          lfsr_d  = (seed == '0) ? LFSR_DEFAULT : seed;
          i_d     = IDXW'(LEN - 1);
          state_d = S_SHUFFLE;
        end
        S_SHUFFLE: begin
          lfsr_d = lfsr_step(lfsr_q);
          if (accept) begin
            for (int k = 0; k < LEN; k++) begin
              if (IDXW'(k) == i_q)    perm_d[k] = perm_j;
              else if (IDXW'(k) == j) perm_d[k] = perm_i;
            end
            if (i_q == IDXW'(1)) state_d = S_READY;
            else                 i_d     = i_q - IDXW'(1);
          end
        end
        S_READY: begin
          state_d = S_READY;
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
  end

  always_comb begin
    lookup = '0;
    for (int k = 0; k < LEN; k++) begin
      if (biasidx[k]) lookup = lookup | perm_q[k];
    end
    valtotry_d = (state_q == S_READY) ? lookup : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      lfsr_q     <= LFSR_DEFAULT;
      i_q        <= IDXW'(LEN - 1);
      valtotry_q <= '0;
      for (int k = 0; k < LEN; k++) perm_q[k] <= LEN'(1) << k;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      i_q        <= i_d;
      valtotry_q <= valtotry_d;
      for (int k = 0; k < LEN; k++) perm_q[k] <= perm_d[k];
    end
  end

  assign ready    = (state_q == S_READY);
  assign valtotry = valtotry_q;

`ifdef ROW_BIAS_PROTOCOL_CHECK_EN
  logic err_q;
  logic proto_viol;

  // Multi-hot index, or any request while the permutation is not valid.
  assign proto_viol = ((biasidx & (biasidx - LEN'(1))) != '0) ||
                      ((biasidx != '0) && (state_q != S_READY));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)           err_q <= 1'b0;
    else if (proto_viol) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_row_bias.sv
// tb_row_bias: randomized self-checking bench for row_bias (LEN=9) against a Fisher-Yates reference model.
module tb_row_bias;

  localparam int LEN  = 9;
  localparam int JMOD = 1 << $clog2(LEN);
`ifdef ROW_BIAS_PROTOCOL_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [15:0]     seed;
  logic            ready;
  logic [LEN-1:0]  biasidx;
  logic [LEN-1:0]  valtotry;
  logic            err;

  int              n_checks = 0;
  int              n_errors = 0;
  logic [LEN-1:0]  exp_perm [LEN];
  int              exp_att;

  row_bias #(.LEN(LEN), .SEEDW(16)) dut (
    .clock   (clk),
    .reset   (rst),
    .start   (start),
    .seed    (seed),
    .ready   (ready),
    .biasidx (biasidx),
    .valtotry(valtotry),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain Fisher-Yates driven by the LFSR sequence, counting draws.
  task automatic model(input logic [15:0] s);
    int unsigned x;
    int i, jj;
    logic [LEN-1:0] t;
    x = (s == 16'h0000) ? 32'hACE1 : 32'(s);
    for (int k = 0; k < LEN; k++) exp_perm[k] = LEN'(1) << k;
    i = LEN - 1;
    exp_att = 0;
    while (i >= 1) begin
      jj = int'(x % JMOD);
      x = (x % 2 == 1) ? ((x / 2) ^ 32'hB400) : (x / 2);
      exp_att++;
      if (jj <= i) begin
        t = exp_perm[i];
        exp_perm[i] = exp_perm[jj];
        exp_perm[jj] = t;
        i--;
      end
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!ready && cnt < 256);
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic read_perm(input string tag);
    logic [LEN-1:0] acc;
    acc = '0;
    for (int k = 0; k < LEN; k++) begin
      biasidx = LEN'(1) << k;
      @(posedge clk); #1;
      check($sformatf("%s_slot%0d", tag, k), 32'(valtotry), 32'(exp_perm[k]));
      check($sformatf("%s_onehot%0d", tag, k), 32'($countones(valtotry)), 32'd1);
      acc = acc | valtotry;
    end
    biasidx = '0;
    check($sformatf("%s_or_all", tag), 32'(acc), 32'h1FF);
  endtask

  task automatic do_start(input logic [15:0] s);
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input logic [15:0] s, input string tag, output int cnt);
    model(s);
    do_start(s);
    wait_ready(cnt);
    check($sformatf("%s_cycles", tag), 32'(cnt), 32'(1 + exp_att));
    read_perm(tag);
  endtask

  initial begin
    int cnt, cnt_zero, cnt_ace;
    logic [15:0] rs;

    rst = 1'b1; start = 1'b0; seed = 16'h1234; biasidx = '0;

    // Reset state and first shuffle
    #12;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valtotry", 32'(valtotry), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    model(16'h1234);
    rst = 1'b0;
    wait_ready(cnt);
    check("s1234_cycles", 32'(cnt), 32'(1 + exp_att));
    read_perm("s1234");

    // Empty index and held index
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("empty_idx", 32'(valtotry), 32'd0);
    end
    biasidx = 9'h010;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("held_idx", 32'(valtotry), 32'(exp_perm[4]));
    end
    biasidx = '0;
    @(posedge clk); #1;

    // Zero seed maps to the default seed
    run(16'h0000, "s0000", cnt_zero);
    run(16'hACE1, "sACE1", cnt_ace);
    check("zero_vs_ace1_cycles", 32'(cnt_zero), 32'(cnt_ace));

    for (int r = 0; r < 4; r++) begin
      rs = 16'($urandom_range(0, 65535));
      run(rs, $sformatf("rnd%0d", r), cnt);
    end

    // Restart mid-shuffle
    do_start(16'h4321);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("midshuf_ready", 32'(ready), 32'd0);
    end
    run(16'h00FF, "s00FF", cnt);

    // Asynchronous reset mid-shuffle
    rs = 16'($urandom_range(1, 65535));
    do_start(rs);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("areset_shuf_ready", 32'(ready), 32'd0);
    check("areset_shuf_val", 32'(valtotry), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    model(rs);
    wait_ready(cnt);
    check("after_areset_cycles", 32'(cnt), 32'(1 + exp_att));
    read_perm("after_areset");

    // Asynchronous reset while a lookup is being served
    biasidx = 9'h004;
    @(posedge clk); #1;
    check("ready_lookup", 32'(valtotry), 32'(exp_perm[2]));
    #2 rst = 1'b1;
    #1;
    check("areset_ready_val", 32'(valtotry), 32'd0);
    check("areset_ready_rdy", 32'(ready), 32'd0);
    biasidx = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    wait_ready(cnt);
    read_perm("after_areset2");

    // Protocol checking: multi-hot lookup
    check("err_clean", 32'(err), 32'd0);
    biasidx = 9'h003;
    @(posedge clk); #1;
    check("err_multihot", 32'(err), 32'(CHK_EN));
    check("multihot_val", 32'(valtotry), 32'(exp_perm[0] | exp_perm[1]));
    biasidx = 9'h1FF;
    @(posedge clk); #1;
    check("allhot_val", 32'(valtotry), 32'h1FF);
    biasidx = '0;
    run(16'h5555, "s5555", cnt);
    check("err_after_start", 32'(err), 32'(CHK_EN));
    #2 rst = 1'b1;
    #1;
    check("err_reset", 32'(err), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    biasidx = 9'h010;
    @(posedge clk); #1;
    check("err_not_ready", 32'(err), 32'(CHK_EN));
    check("val_not_ready", 32'(valtotry), 32'd0);
    biasidx = '0;
    wait_ready(cnt);
    check("err_sticky", 32'(err), 32'(CHK_EN));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
